load_store_unit: RTL and testbench

//  Memory stage directly downstream of the ALU: takes the ALU result as the effective address,

---
 rtl/load_store_unit.sv | 198 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: memory stage behind the ALU.
// Turns one load or store into a single req/gnt/rvalid data-memory transaction,
// stalls the core while the access is in flight, and aborts the access if the
// bus does not answer within TIMEOUT_CYCLES cycles.
//
//  state | meaning
//  ------+--------------------------------------------------------------
//  IDLE  | no access in flight; legal access is captured and stalls now
//  REQ   | mem_req_o high from captured regs, waiting for mem_gnt_i
//  WAIT  | load granted, waiting for mem_rvalid_i
//  DONE  | one-cycle completion slot: ld_valid_o or err_o, stall released

module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] st_data_i,
    input  logic        ld_en_i,
    input  logic        st_en_i,
    input  logic [2:0]  lsu_op_i,
    output logic        stall_o,
    output logic [31:0] ld_data_o,
    output logic        ld_valid_o,
    output logic        misalign_o,
    output logic        err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_be_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    // Last count value at which the bus may still answer.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [1:0]  state;
    logic [1:0]  state_next;
    logic [7:0]  tmo_cnt;
    logic        tmo_hit;

    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic [2:0]  op_q;
    logic        we_q;
    logic        ld_valid_q;
    logic        err_q;
    logic [31:0] ld_data_q;

    logic        access;
    logic        op_illegal;
    logic        misaligned;
    logic        reject;
    logic        start;

    logic [3:0]  be_lane;
    logic [31:0] wdata_lane;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] ld_ext;

    // Decode the incoming instruction: legal access starts, anything else is rejected.
    always_comb begin
        access     = ld_en_i ^ st_en_i;
        op_illegal = (lsu_op_i == 3'b011) || (lsu_op_i[2:1] == 2'b11) ||
                     (st_en_i && lsu_op_i[2]);
        misaligned = ((lsu_op_i[1:0] == 2'b01) && addr_i[0]) ||
                     ((lsu_op_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));
        reject     = (ld_en_i && st_en_i) || (access && (op_illegal || misaligned));
        start      = access && !op_illegal && !misaligned;
        tmo_hit    = (tmo_cnt == TMO_LAST);
    end

    // Next-state logic; rvalid alongside gnt in REQ is deliberately not looked at.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = REQ;
            REQ: begin
                if (mem_gnt_i)    state_next = we_q ? DONE : WAIT;
                else if (tmo_hit) state_next = DONE;
            end
            WAIT: if (mem_rvalid_i || tmo_hit) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register, timeout counter and completion pulses.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            tmo_cnt    <= 8'd0;
            ld_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state      <= state_next;
            ld_valid_q <= 1'b0;
            err_q      <= 1'b0;
            case (state)
                IDLE: if (start) tmo_cnt <= 8'd0;
                REQ: begin
                    tmo_cnt <= tmo_cnt + 8'd1;
                    if (!mem_gnt_i && tmo_hit) err_q <= 1'b1;
                end
                WAIT: begin
                    tmo_cnt <= tmo_cnt + 8'd1;
                    if (mem_rvalid_i)  ld_valid_q <= 1'b1;
                    else if (tmo_hit)  err_q      <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Capture the access at start so later input changes cannot disturb the bus;
    // the load result register only changes on a completed read.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q    <= 32'd0;
            data_q    <= 32'd0;
            op_q      <= 3'd0;
            we_q      <= 1'b0;
            ld_data_q <= 32'd0;
        end else begin
            if (state == IDLE && start) begin
                addr_q <= addr_i;
                data_q <= st_data_i;
                op_q   <= lsu_op_i;
                we_q   <= st_en_i;
            end
            if (state == WAIT && mem_rvalid_i) ld_data_q <= ld_ext;
        end
    end

    // Byte enables and lane-replicated write data from the captured access.
    always_comb begin
        be_lane    = 4'b1111;
        wdata_lane = data_q;
        case (op_q[1:0])
            2'b00: begin
                be_lane    = 4'b0001 << addr_q[1:0];
                wdata_lane = {4{data_q[7:0]}};
            end
            2'b01: begin
                be_lane    = addr_q[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{data_q[15:0]}};
            end
            default: begin
                be_lane    = 4'b1111;
                wdata_lane = data_q;
            end
        endcase
    end

    // Lane select and sign/zero extension of the returned read word.
    always_comb begin
        case (addr_q[1:0])
            2'b00:   rd_byte = mem_rdata_i[7:0];
            2'b01:   rd_byte = mem_rdata_i[15:8];
            2'b10:   rd_byte = mem_rdata_i[23:16];
            default: rd_byte = mem_rdata_i[31:24];
        endcase
        rd_half = addr_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        case (op_q)
            3'b000:  ld_ext = {{24{rd_byte[7]}}, rd_byte};
            3'b100:  ld_ext = {24'd0, rd_byte};
            3'b001:  ld_ext = {{16{rd_half[15]}}, rd_half};
            3'b101:  ld_ext = {16'd0, rd_half};
            default: ld_ext = mem_rdata_i;
        endcase
    end

    // Output drive; stall and misalign are gated by reset so they drop immediately.
    always_comb begin
        mem_req_o   = (state == REQ);
        mem_we_o    = mem_req_o && we_q;
        mem_addr_o  = mem_req_o ? {addr_q[31:2], 2'b00} : 32'd0;
        mem_be_o    = mem_req_o ? be_lane : 4'd0;
        mem_wdata_o = mem_req_o ? wdata_lane : 32'd0;
        stall_o     = !rst_i && ((state == REQ) || (state == WAIT) ||
                                 ((state == IDLE) && start));
        misalign_o  = !rst_i && (state == IDLE) && reject;
        ld_valid_o  = ld_valid_q;
        err_o       = err_q;
        ld_data_o   = ld_data_q;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a short timeout (4 cycles).
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = 32'd0;
    logic [31:0] st_data = 32'd0;
    logic        ld_en = 1'b0;
    logic        st_en = 1'b0;
    logic [2:0]  lsu_op = 3'd0;
    logic        stall;
    logic [31:0] ld_data;
    logic        ld_valid;
    logic        misalign;
    logic        err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        gnt = 1'b0;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = 32'd0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk_i(clk), .rst_i(rst), .addr_i(addr), .st_data_i(st_data),
        .ld_en_i(ld_en), .st_en_i(st_en), .lsu_op_i(lsu_op),
        .stall_o(stall), .ld_data_o(ld_data), .ld_valid_o(ld_valid),
        .misalign_o(misalign), .err_o(err), .mem_req_o(mem_req),
        .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_be_o(mem_be), .mem_gnt_i(gnt), .mem_rvalid_i(rvalid),
        .mem_rdata_i(rdata)
    );

    typedef struct {
        logic        ld;
        logic        st;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] d;
        int          gnt_n;     // grant on this REQ cycle (1 = first); 0 = never
        int          rv_dly;    // extra cycles after gnt before rvalid; 99 = never
        logic        junk;      // also raise rvalid (with wrong data) together with gnt
        logic [31:0] rd;
        int          e_mis;
        int          e_req;
        int          e_stall;
        int          e_valid;
        int          e_err;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic [31:0] e_maddr;
        logic        e_we;
        logic [31:0] e_ld;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one access over a fixed 10-cycle window, acting as the memory and
    // scrambling the core-side inputs after the first cycle.
    task automatic run_access(input int idx, input vec_t v);
        int n_mis, n_req, n_stall, n_valid, n_err, req_seen, rv_at;
        logic granted;
        logic [3:0]  be_s;
        logic [31:0] wd_s, ma_s;
        logic        we_s;
        n_mis = 0; n_req = 0; n_stall = 0; n_valid = 0; n_err = 0;
        req_seen = 0; rv_at = -1; granted = 1'b0;
        be_s = 4'd0; wd_s = 32'd0; ma_s = 32'd0; we_s = 1'b0;
        for (int c = 0; c < 10; c++) begin
            gnt = 1'b0; rvalid = 1'b0; rdata = 32'd0;
            if (c == 0) begin
                ld_en = v.ld; st_en = v.st; lsu_op = v.op; addr = v.a; st_data = v.d;
            end else begin
                ld_en = 1'b0; st_en = 1'b0; lsu_op = 3'b010;
                addr = ~v.a; st_data = ~v.d;
            end
            if (mem_req && !granted) begin
                req_seen++;
                if (req_seen == v.gnt_n) begin
                    gnt = 1'b1;
                    granted = 1'b1;
                    rv_at = c + 1 + v.rv_dly;
                    if (v.junk) begin rvalid = 1'b1; rdata = ~v.rd; end
                end
            end
            if (granted && v.ld && c == rv_at) begin rvalid = 1'b1; rdata = v.rd; end
            #1;
            if (stall)    n_stall++;
            if (misalign) n_mis++;
            if (ld_valid) n_valid++;
            if (err)      n_err++;
            if (mem_req) begin
                n_req++;
                be_s = mem_be; wd_s = mem_wdata; ma_s = mem_addr; we_s = mem_we;
            end
            tick();
        end
        gnt = 1'b0; rvalid = 1'b0;
        chk($sformatf("v%0d misalign", idx), n_mis, v.e_mis);
        chk($sformatf("v%0d req_cycles", idx), n_req, v.e_req);
        chk($sformatf("v%0d stall_cycles", idx), n_stall, v.e_stall);
        chk($sformatf("v%0d ld_valid", idx), n_valid, v.e_valid);
        chk($sformatf("v%0d err", idx), n_err, v.e_err);
        chk($sformatf("v%0d ld_data", idx), ld_data, v.e_ld);
        if (v.e_req > 0) begin
            chk($sformatf("v%0d mem_addr", idx), ma_s, v.e_maddr);
            chk($sformatf("v%0d mem_we", idx), {31'd0, we_s}, {31'd0, v.e_we});
            if (v.st) begin
                chk($sformatf("v%0d mem_be", idx), {28'd0, be_s}, {28'd0, v.e_be});
                chk($sformatf("v%0d mem_wdata", idx), wd_s, v.e_wdata);
            end
        end
    endtask

    initial begin
        logic [7:0] stall_bits;
        int         nvalid;

        // Reset: outputs must stay 0 even with a legal load presented.
        ld_en = 1'b1; lsu_op = 3'b010; addr = 32'h0;
        #2;
        chk("rst stall", {31'd0, stall}, 32'd0);
        chk("rst misalign", {31'd0, misalign}, 32'd0);
        chk("rst mem_req", {31'd0, mem_req}, 32'd0);
        ld_en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst ld_data", ld_data, 32'd0);
        chk("rst ld_valid", {31'd0, ld_valid}, 32'd0);
        chk("rst err", {31'd0, err}, 32'd0);
        chk("rst be", {28'd0, mem_be}, 32'd0);
        tick();

        //              ld    st    op      addr        data          gn rv  jk   rdata          mis req stl val err be     wdata          maddr       we    ld_data
        vecs.push_back('{1'b0, 1'b1, 3'b010, 32'h104, 32'hDEADBEEF, 2, 0,  1'b0, 32'h0,        0, 2, 3, 0, 0, 4'hF, 32'hDEADBEEF, 32'h104, 1'b1, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 3'b000, 32'h203, 32'h0,        1, 0,  1'b0, 32'h80123456, 0, 1, 3, 1, 0, 4'h8, 32'h0,        32'h200, 1'b0, 32'hFFFFFF80});
        vecs.push_back('{1'b1, 1'b0, 3'b100, 32'h203, 32'h0,        1, 0,  1'b0, 32'h80123456, 0, 1, 3, 1, 0, 4'h8, 32'h0,        32'h200, 1'b0, 32'h00000080});
        vecs.push_back('{1'b0, 1'b1, 3'b001, 32'h102, 32'h1234ABCD, 1, 0,  1'b0, 32'h0,        0, 1, 2, 0, 0, 4'hC, 32'hABCDABCD, 32'h100, 1'b1, 32'h00000080});
        vecs.push_back('{1'b1, 1'b0, 3'b001, 32'h101, 32'h0,        1, 0,  1'b0, 32'h0,        1, 0, 0, 0, 0, 4'h0, 32'h0,        32'h0,   1'b0, 32'h00000080});
        vecs.push_back('{1'b1, 1'b0, 3'b010, 32'h500, 32'h0,        0, 0,  1'b0, 32'h0,        0, 4, 5, 0, 1, 4'hF, 32'h0,        32'h500, 1'b0, 32'h00000080});
        vecs.push_back('{1'b1, 1'b0, 3'b001, 32'h206, 32'h0,        1, 0,  1'b0, 32'h80017FFF, 0, 1, 3, 1, 0, 4'hC, 32'h0,        32'h204, 1'b0, 32'hFFFF8001});
        vecs.push_back('{1'b1, 1'b0, 3'b101, 32'h206, 32'h0,        1, 0,  1'b0, 32'h80017FFF, 0, 1, 3, 1, 0, 4'hC, 32'h0,        32'h204, 1'b0, 32'h00008001});
        vecs.push_back('{1'b1, 1'b0, 3'b001, 32'h204, 32'h0,        1, 0,  1'b0, 32'h1234F00F, 0, 1, 3, 1, 0, 4'h3, 32'h0,        32'h204, 1'b0, 32'hFFFFF00F});
        vecs.push_back('{1'b1, 1'b0, 3'b000, 32'h201, 32'h0,        1, 0,  1'b0, 32'h00007F00, 0, 1, 3, 1, 0, 4'h2, 32'h0,        32'h200, 1'b0, 32'h0000007F});
        vecs.push_back('{1'b0, 1'b1, 3'b000, 32'h103, 32'h000000A5, 1, 0,  1'b0, 32'h0,        0, 1, 2, 0, 0, 4'h8, 32'hA5A5A5A5, 32'h100, 1'b1, 32'h0000007F});
        vecs.push_back('{1'b0, 1'b1, 3'b100, 32'h100, 32'h00000055, 1, 0,  1'b0, 32'h0,        1, 0, 0, 0, 0, 4'h0, 32'h0,        32'h0,   1'b0, 32'h0000007F});
        vecs.push_back('{1'b1, 1'b0, 3'b011, 32'h100, 32'h0,        1, 0,  1'b0, 32'h0,        1, 0, 0, 0, 0, 4'h0, 32'h0,        32'h0,   1'b0, 32'h0000007F});
        vecs.push_back('{1'b1, 1'b1, 3'b010, 32'h0,   32'h0,        1, 0,  1'b0, 32'h0,        1, 0, 0, 0, 0, 4'h0, 32'h0,        32'h0,   1'b0, 32'h0000007F});
        vecs.push_back('{1'b1, 1'b0, 3'b010, 32'h102, 32'h0,        1, 0,  1'b0, 32'h0,        1, 0, 0, 0, 0, 4'h0, 32'h0,        32'h0,   1'b0, 32'h0000007F});
        vecs.push_back('{1'b1, 1'b0, 3'b010, 32'h300, 32'h0,        1, 0,  1'b1, 32'hCAFEF00D, 0, 1, 3, 1, 0, 4'hF, 32'h0,        32'h300, 1'b0, 32'hCAFEF00D});
        vecs.push_back('{1'b1, 1'b0, 3'b010, 32'h304, 32'h0,        1, 99, 1'b0, 32'h11111111, 0, 1, 5, 0, 1, 4'hF, 32'h0,        32'h304, 1'b0, 32'hCAFEF00D});
        vecs.push_back('{1'b1, 1'b0, 3'b010, 32'h308, 32'h0,        3, 0,  1'b0, 32'h13579BDF, 0, 3, 5, 1, 0, 4'hF, 32'h0,        32'h308, 1'b0, 32'h13579BDF});
        vecs.push_back('{1'b0, 1'b1, 3'b010, 32'h10C, 32'h01020304, 4, 0,  1'b0, 32'h0,        0, 4, 5, 0, 0, 4'hF, 32'h01020304, 32'h10C, 1'b1, 32'h13579BDF});
        vecs.push_back('{1'b1, 1'b0, 3'b110, 32'h0,   32'h0,        1, 0,  1'b0, 32'h0,        1, 0, 0, 0, 0, 4'h0, 32'h0,        32'h0,   1'b0, 32'h13579BDF});

        foreach (vecs[i]) run_access(i, vecs[i]);

        // Back-to-back loads with ld_en held: exactly one non-stalled DONE cycle between them.
        stall_bits = 8'd0;
        for (int c = 0; c < 8; c++) begin
            gnt = 1'b0; rvalid = 1'b0; rdata = 32'd0;
            ld_en = (c < 7); st_en = 1'b0; lsu_op = 3'b010;
            addr = (c < 4) ? 32'h600 : 32'h604;
            if (c == 1 || c == 5) gnt = 1'b1;
            if (c == 2) begin rvalid = 1'b1; rdata = 32'hA5A50001; end
            if (c == 6) begin rvalid = 1'b1; rdata = 32'h5A5A0002; end
            #1;
            stall_bits[c] = stall;
            if (c == 1) chk("b2b addr0", mem_addr, 32'h600);
            if (c == 3) begin
                chk("b2b valid0", {31'd0, ld_valid}, 32'd1);
                chk("b2b data0", ld_data, 32'hA5A50001);
            end
            if (c == 5) chk("b2b addr1", mem_addr, 32'h604);
            if (c == 7) begin
                chk("b2b valid1", {31'd0, ld_valid}, 32'd1);
                chk("b2b data1", ld_data, 32'h5A5A0002);
            end
            tick();
        end
        gnt = 1'b0; rvalid = 1'b0; ld_en = 1'b0;
        chk("b2b stall pattern", {24'd0, stall_bits}, 32'h77);
        tick();

        // Reset while in REQ: request and stall fall at once.
        ld_en = 1'b1; lsu_op = 3'b010; addr = 32'h700;
        #1;
        tick();
        ld_en = 1'b0;
        #1;
        chk("rstreq req before", {31'd0, mem_req}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rstreq req", {31'd0, mem_req}, 32'd0);
        chk("rstreq stall", {31'd0, stall}, 32'd0);
        tick();
        rst = 1'b0;

        // Reset while in WAIT: stall falls; a late rvalid is ignored.
        ld_en = 1'b1; lsu_op = 3'b010; addr = 32'h800;
        #1;
        tick();
        ld_en = 1'b0; gnt = 1'b1;
        #1;
        tick();
        gnt = 1'b0;
        #1;
        chk("rstwait stall before", {31'd0, stall}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rstwait stall", {31'd0, stall}, 32'd0);
        chk("rstwait req", {31'd0, mem_req}, 32'd0);
        tick();
        rst = 1'b0;
        rvalid = 1'b1; rdata = 32'hFFFF0000;
        nvalid = 0;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (ld_valid) nvalid++;
            tick();
            rvalid = 1'b0;
        end
        chk("rstwait late ld_valid", nvalid, 32'd0);
        chk("rstwait ld_data", ld_data, 32'd0);
        chk("rstwait stall after", {31'd0, stall}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
